// File: rtl/decoder_38_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready input, programmable hold and one idle gap cycle.
// Optional one-entry skid buffer for back-to-back pulses: define DECODER_38_SKID_EN.
module decoder_38_seq #(
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned HOLD_W = 4,
    localparam int unsigned OUT_W = 1 << IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [HOLD_W-1:0] in_hold,
    output logic [OUT_W-1:0]  y,
    output logic              out_active,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t            state;
    logic [HOLD_W-1:0] cnt;
    logic              accept;

`ifdef DECODER_38_SKID_EN
    logic              buf_full;
    logic [IDX_W-1:0]  buf_idx;
    logic [HOLD_W-1:0] buf_hold;
`endif

    assign accept = in_valid & in_ready;

    function automatic logic [OUT_W-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            y          <= '0;
            out_active <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
`ifdef DECODER_38_SKID_EN
            buf_full   <= 1'b0;
            buf_idx    <= '0;
            buf_hold   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef DECODER_38_SKID_EN
                    in_ready <= 1'b1;
                    if (buf_full) begin
                        state      <= DRIVE;
                        cnt        <= buf_hold;
                        y          <= onehot(buf_idx);
                        out_active <= 1'b1;
                        done       <= (buf_hold == '0);
                        buf_full   <= 1'b0;
                    end else if (accept) begin
`else
                    in_ready <= !accept;
                    if (accept) begin
`endif
                        state      <= DRIVE;
                        cnt        <= in_hold;
                        y          <= onehot(in_idx);
                        out_active <= 1'b1;
                        done       <= (in_hold == '0);
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt  <= cnt - 1'b1;
                        done <= (cnt == HOLD_W'(1));
`ifdef DECODER_38_SKID_EN
                    end else if (buf_full) begin
                        // buffered entry replaces the gap; buffer frees on this edge
                        cnt        <= buf_hold;
                        y          <= onehot(buf_idx);
                        out_active <= 1'b1;
                        done       <= (buf_hold == '0);
                        buf_full   <= 1'b0;
                        in_ready   <= 1'b1;
`endif
                    end else begin
                        state      <= GAP;
                        y          <= '0;
                        out_active <= 1'b0;
                    end
                end
                GAP: begin
                    state <= IDLE;
`ifndef DECODER_38_SKID_EN
                    in_ready <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
`ifdef DECODER_38_SKID_EN
            // accepted while busy goes to the buffer; in_ready=0 rules out a clash with a buffer load
            if (state != IDLE && accept) begin
                buf_full <= 1'b1;
                buf_idx  <= in_idx;
                buf_hold <= in_hold;
                in_ready <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_decoder_38_seq.sv
// Scoreboard bench for decoder_38_seq: accepted transfers are queued, a monitor matches pulses.
module tb_decoder_38_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic [3:0] in_hold;
    logic [7:0] y;
    logic       out_active;
    logic       done;

    decoder_38_seq #(.IDX_W(3), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_hold(in_hold), .y(y), .out_active(out_active), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        int unsigned hold;
        int          acc;
    } item_t;

    item_t      sb[$];
    item_t      cur;
    logic       cur_v = 1'b0;
    int unsigned len = 0;
    logic       prev_done = 1'b0;
    int         cyc = 0;
    int         busy_until = 0;
    logic [7:0] ytrace[$];
    int         tests = 0;
    int         fails = 0;
    int         acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: y/done/ready versus the transfer-level model
    always @(negedge clk) begin
        if (rst_n) begin
            ytrace.push_back(y);
`ifndef DECODER_38_SKID_EN
            check("in_ready", {31'b0, in_ready}, {31'b0, cyc >= busy_until});
            if (prev_done) check("gap", {24'b0, y}, 32'h0);
`endif
            check("out_active", {31'b0, out_active}, {31'b0, y != 8'h0});
            if (y != 8'h0) begin
                if (!cur_v) begin
                    check("unexpected_pulse", {31'b0, sb.size() != 0}, 32'h1);
                    if (sb.size() != 0) begin
                        cur   = sb.pop_front();
                        cur_v = 1'b1;
                        len   = 0;
`ifndef DECODER_38_SKID_EN
                        check("latency", cyc, cur.acc);
`endif
                    end
                end
                if (cur_v) begin
                    logic [7:0] exp_y;
                    exp_y = 8'h1 << cur.idx;
                    len++;
                    check("y", {24'b0, y}, {24'b0, exp_y});
                    check("done", {31'b0, done}, {31'b0, len == cur.hold + 1});
                    if (done || len >= cur.hold + 1) cur_v = 1'b0;
                end
            end else begin
                check("done_idle", {31'b0, done}, 32'h0);
                if (cur_v) check("truncated_len", len, cur.hold + 1);
                cur_v = 1'b0;
            end
            prev_done = done;
            if (in_valid && in_ready) begin
                sb.push_back('{idx: in_idx, hold: in_hold, acc: cyc + 1});
                busy_until = cyc + 1 + int'(in_hold) + 2;
            end
        end
    end

    task automatic send(input int unsigned idx, input int unsigned hold);
        int n = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        while (!acc && n < 60) begin
            if (in_ready) begin
                in_idx  = 3'(idx);
                in_hold = 4'(hold);
            end else begin
                in_idx  = 3'($urandom);
                in_hold = 4'($urandom);
            end
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_idx   = 3'($urandom);
        acc_cyc  = cyc;
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout: got no accept, expected accept within 60 cycles");
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        busy_until = cyc + 1;
        check("ready_pre_edge", {31'b0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("ready_after_release", {31'b0, in_ready}, 32'h1);
    endtask

    initial begin
        int prev;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_idx   = '0;
        in_hold  = '0;
        #1;
        check("rst_y", {24'b0, y}, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h0);
        check("rst_active", {31'b0, out_active}, 32'h0);
        idle(2);
        release_reset();

        // asynchronous reset in the middle of a long pulse
        send(5, 10);
        idle(3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y", {24'b0, y}, 32'h0);
        check("async_active", {31'b0, out_active}, 32'h0);
        check("async_ready", {31'b0, in_ready}, 32'h0);
        sb.delete();
        cur_v = 1'b0;
        prev_done = 1'b0;
        @(posedge clk);
        #1;
        check("held_rst_y", {24'b0, y}, 32'h0);
        release_reset();

        send(3, 0);
        idle(4);

        for (int unsigned i = 0; i < 8; i++) begin
            prev = acc_cyc;
            send(i, 2);
`ifndef DECODER_38_SKID_EN
            if (i > 0) check("sweep_spacing", acc_cyc - prev, 5);
`endif
        end
        idle(6);

        send(7, 15);
        idle(20);

        for (int k = 0; k < 40; k++) begin
            send($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 4));
            idle($urandom_range(0, 3));
        end

`ifdef DECODER_38_SKID_EN
        idle(25);
        ytrace.delete();
        send(1, 1);
        send(6, 0);
        idle(6);
        begin
            int f = -1;
            for (int i = 0; i < ytrace.size(); i++)
                if (f < 0 && ytrace[i] != 8'h0) f = i;
            check("skid_found", {31'b0, f >= 0 && f + 3 < ytrace.size()}, 32'h1);
            if (f >= 0 && f + 3 < ytrace.size()) begin
                check("skid_0", {24'b0, ytrace[f]},   32'h02);
                check("skid_1", {24'b0, ytrace[f+1]}, 32'h02);
                check("skid_2", {24'b0, ytrace[f+2]}, 32'h40);
                check("skid_3", {24'b0, ytrace[f+3]}, 32'h00);
            end
        end
`endif

        n = 0;
        while ((sb.size() != 0 || cur_v) && n < 60) begin
            idle(1);
            n++;
        end
        check("drain", {31'b0, sb.size() == 0 && !cur_v}, 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
